// File: rtl/mux_sel_scanner_pkg.sv
// Shared types and helpers for the mux select scanner: FSM states, channel
// geometry and the select stepping order (binary or Gray).
package mux_scan_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } scan_state_e;

  // Gray order visits 0,1,3,2 so only one select line toggles per step.
  function automatic sel_t next_sel(input sel_t cur, input logic gray);
    sel_t nxt;
    if (gray) begin
      case (cur)
        2'd0:    nxt = 2'd1;
        2'd1:    nxt = 2'd3;
        2'd3:    nxt = 2'd2;
        default: nxt = 2'd0;
      endcase
    end else begin
      nxt = cur + 2'd1;
    end
    return nxt;
  endfunction

  function automatic sel_t last_sel(input logic gray);
    return gray ? 2'd2 : 2'd3;
  endfunction

endpackage

// File: rtl/mux_sel_scanner_if.sv
// Bus between the scanner and the tt_um mux/pad logic: control inputs,
// the returned mux bit and the select/snapshot status outputs.
interface mux_sel_scanner_if
  import mux_scan_pkg::*;
();

  logic             ena;
  logic             mode_auto;
  logic             btn_step;
  logic             mux_out;
  logic [SEL_W-1:0] select;
  logic [N_CH-1:0]  snapshot;
  logic             snap_valid;
  logic             busy;

  modport master (
    output ena, mode_auto, btn_step, mux_out,
    input  select, snapshot, snap_valid, busy
  );

  modport slave (
    input  ena, mode_auto, btn_step, mux_out,
    output select, snapshot, snap_valid, busy
  );

endinterface

// File: rtl/mux_sel_scanner_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ena,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_q;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else if (i_ena) begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_rise = r_level & ~r_level_q;

endmodule

// File: rtl/mux_sel_scanner.sv
// Mux select scanner: steps the 4:1 select on a prescaler tick or button,
// settles, then snapshots mux_out per channel. SCAN_GRAY_EN selects Gray order.
module mux_sel_scanner
  import mux_scan_pkg::*;
#(
  parameter int PERIOD          = 50000,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_sel_scanner_if.slave   bus
);

`ifdef SCAN_GRAY_EN
  localparam logic GRAY_ORDER = 1'b1;
`else
  localparam logic GRAY_ORDER = 1'b0;
`endif

  localparam int   PRE_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam int   CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam sel_t LAST  = last_sel(GRAY_ORDER);

  logic [PRE_W-1:0] r_presc;
  logic [CNT_W-1:0] r_cnt;
  scan_state_e      r_state;
  sel_t             r_select;
  logic [N_CH-1:0]  r_snapshot;
  logic             r_snap_valid;
  logic             r_busy;

  logic w_tick;
  logic w_manual;
  logic w_step;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_ena  (bus.ena),
    .i_btn  (bus.btn_step),
    .o_rise (w_manual)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (bus.ena) begin
      if (!bus.mode_auto || w_tick) r_presc <= '0;
      else                          r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick = (r_presc == PRE_W'(PERIOD - 1));
  assign w_step = bus.ena & (bus.mode_auto ? w_tick : w_manual);

  // Steps arriving outside IDLE are simply not looked at, hence dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_select     <= '0;
      r_snapshot   <= '0;
      r_snap_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else if (!bus.ena) begin
      r_snap_valid <= 1'b0;
    end else begin
      r_snap_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_step) begin
            r_select <= next_sel(r_select, GRAY_ORDER);
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= SETTLE;
          end
        end
        SETTLE: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) r_state <= SAMPLE;
        end
        SAMPLE: begin
          r_snapshot[r_select] <= bus.mux_out;
          r_snap_valid         <= (r_select == LAST);
          r_busy               <= 1'b0;
          r_state              <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.select     = r_select;
  assign bus.snapshot   = r_snapshot;
  assign bus.snap_valid = r_snap_valid;
  assign bus.busy       = r_busy;

endmodule
